// File: rtl/mux_pkg.sv
// Shared constants and types for the 7-lane selector.
package mux_pkg;
  localparam int unsigned NUM_LANES   = 7;
  localparam int unsigned SEL_W       = 3;
  localparam logic [SEL_W-1:0] SEL_ILLEGAL = 3'd7;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_7_to_1_core.sv
// Combinational 7:1 lane select with illegal-code detect; zero latency, no backpressure.
module mux_7_to_1_core
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [NUM_LANES*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out,
  output logic                       sel_err
);

  sel_t sel_s;
  assign sel_s = sel;

  // Illegal code drives zeros rather than X so downstream logic stays clean.
  always_comb begin
    out     = '0;
    sel_err = 1'b0;
    case (sel_s)
      3'd0:    out = in[0*WIDTH +: WIDTH];
      3'd1:    out = in[1*WIDTH +: WIDTH];
      3'd2:    out = in[2*WIDTH +: WIDTH];
      3'd3:    out = in[3*WIDTH +: WIDTH];
      3'd4:    out = in[4*WIDTH +: WIDTH];
      3'd5:    out = in[5*WIDTH +: WIDTH];
      3'd6:    out = in[6*WIDTH +: WIDTH];
      default: sel_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mux_7_to_1.sv
// Registered 7:1 lane selector; 1-cycle latency when REG_OUT=1, else combinational.
// No handshake: in/sel are sampled every cycle, nothing can stall it.
module mux_7_to_1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out,
  output logic                       sel_err
);

  logic [WIDTH-1:0] out_d;
  logic             err_d;

  mux_7_to_1_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .in      (in),
    .sel     (sel),
    .out     (out_d),
    .sel_err (err_d)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] out_q;
      logic             err_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
          err_q <= 1'b0;
        end else begin
          out_q <= out_d;
          err_q <= err_d;
        end
      end

      assign out     = out_q;
      assign sel_err = err_q;
    end else begin : g_comb
      assign out     = out_d;
      assign sel_err = err_d;
    end
  endgenerate

endmodule

// File: tb/tb_mux_7_to_1.sv
// Scoreboarded bench for registered (WIDTH 1 and 8) and combinational variants.
module tb_mux_7_to_1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  in1 = '0;
  logic [2:0]  sel1 = '0;
  logic        out1;
  logic        err1;
  logic [55:0] in8 = '0;
  logic [2:0]  sel8 = '0;
  logic [7:0]  out8;
  logic        err8;
  logic [6:0]  inc = '0;
  logic [2:0]  selc = '0;
  logic        outc;
  logic        errc;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    int         which;
    logic [7:0] out;
    logic       err;
    string      name;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_7_to_1 #(.WIDTH(1), .REG_OUT(1'b1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1), .out(out1), .sel_err(err1));
  mux_7_to_1 #(.WIDTH(8), .REG_OUT(1'b1)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .out(out8), .sel_err(err8));
  mux_7_to_1 #(.WIDTH(1), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in(inc), .sel(selc), .out(outc), .sel_err(errc));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops every entry whose capture edge has passed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.which == 0) begin
        chk({mon_e.name, "_out"}, {7'b0, out1}, mon_e.out);
        chk({mon_e.name, "_err"}, {7'b0, err1}, {7'b0, mon_e.err});
      end else begin
        chk({mon_e.name, "_out"}, out8, mon_e.out);
        chk({mon_e.name, "_err"}, {7'b0, err8}, {7'b0, mon_e.err});
      end
    end
  end

  task automatic push(input int which, input logic [7:0] exp, input logic err, input string name);
    sb.push_back('{due: cyc + 1, which: which, out: exp, err: err, name: name});
  endtask

  task automatic step1(input logic [6:0] i, input logic [2:0] s, input logic e, input logic er,
                       input string name);
    @(posedge clk);
    #2;
    in1  = i;
    sel1 = s;
    push(0, {7'b0, e}, er, name);
  endtask

  task automatic step8(input logic [2:0] s, input logic [7:0] e, input logic er, input string name);
    @(posedge clk);
    #2;
    sel8 = s;
    push(1, e, er, name);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 8'(sb.size()), 8'd0);
      sb.delete();
    end
  endtask

  initial begin
    // Reset state with non-zero inputs present.
    in1 = 7'b1111111; sel1 = 3'd0;
    in8 = {8'h76, 8'h65, 8'h54, 8'h43, 8'h32, 8'h21, 8'h10}; sel8 = 3'd6;
    #1;
    chk("rst_out1", {7'b0, out1}, 8'd0);
    chk("rst_err1", {7'b0, err1}, 8'd0);
    chk("rst_out8", out8, 8'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_hold_out1", {7'b0, out1}, 8'd0);
    chk("rst_hold_out8", out8, 8'd0);
    rst_n = 1'b1;

    // Walk all selects; lanes 1,3,5 high.
    step1(7'b0101010, 3'd0, 1'b0, 1'b0, "walk0");
    step1(7'b0101010, 3'd1, 1'b1, 1'b0, "walk1");
    step1(7'b0101010, 3'd2, 1'b0, 1'b0, "walk2");
    step1(7'b0101010, 3'd3, 1'b1, 1'b0, "walk3");
    step1(7'b0101010, 3'd4, 1'b0, 1'b0, "walk4");
    step1(7'b0101010, 3'd5, 1'b1, 1'b0, "walk5");
    step1(7'b0101010, 3'd6, 1'b0, 1'b0, "walk6");
    step1(7'b1111111, 3'd7, 1'b0, 1'b1, "walk7");

    // Illegal select recovery.
    step1(7'b0000100, 3'd7, 1'b0, 1'b1, "rec_ill");
    step1(7'b0000100, 3'd2, 1'b1, 1'b0, "rec_ok");

    // Simultaneous in/sel change: must pick new lane 6 of the new input.
    step1(7'b0000001, 3'd0, 1'b1, 1'b0, "simul_a");
    step1(7'b1000000, 3'd6, 1'b1, 1'b0, "simul_b");

    // Wide lanes.
    step8(3'd4, 8'h54, 1'b0, "wide4");
    step8(3'd6, 8'h76, 1'b0, "wide6");
    step8(3'd0, 8'h10, 1'b0, "wide0");
    step8(3'd7, 8'h00, 1'b1, "wide7");
    drain();

    // Async reset mid-stream, between clock edges.
    step1(7'b1111111, 3'd3, 1'b1, 1'b0, "pre_rst");
    step8(3'd5, 8'h65, 1'b0, "pre_rst8");
    drain();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_out1", {7'b0, out1}, 8'd0);
    chk("async_err1", {7'b0, err1}, 8'd0);
    chk("async_out8", out8, 8'd0);
    @(posedge clk);
    #2;
    chk("async_hold_out1", {7'b0, out1}, 8'd0);
    rst_n = 1'b1;
    push(0, 8'd1, 1'b0, "post_rst");
    push(1, 8'h65, 1'b0, "post_rst8");
    drain();

    // Combinational variant: no clock edge between change and check.
    @(posedge clk);
    #2;
    inc = 7'b0101010;
    selc = 3'd1; #1;
    chk("comb1_out", {7'b0, outc}, 8'd1);
    chk("comb1_err", {7'b0, errc}, 8'd0);
    selc = 3'd2; #1;
    chk("comb2_out", {7'b0, outc}, 8'd0);
    chk("comb2_err", {7'b0, errc}, 8'd0);
    selc = 3'd7; #1;
    chk("comb7_out", {7'b0, outc}, 8'd0);
    chk("comb7_err", {7'b0, errc}, 8'd1);
    selc = 3'd5; #1;
    chk("comb5_out", {7'b0, outc}, 8'd1);
    chk("comb5_err", {7'b0, errc}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
